// File: rtl/m_cache_refill_pkg.sv
// Shared constants for the cache refill engine: state encoding, line geometry and word-address helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Defines `EADDR_WIDTH (default 32) when the build does not supply it.
`ifndef EADDR_WIDTH
`define EADDR_WIDTH 32
`endif

package m_cache_refill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_INSTALL = 2'd2
    } refill_state_e;

    localparam int LINE_WORDS  = 4;
    localparam int WORD_BITS   = 32;
    localparam int LINE_BITS   = LINE_WORDS * WORD_BITS;
    localparam int LINE_OFF_W  = 4;   // byte offset inside a 16-byte line
    localparam int BYTE_OFF_W  = 2;   // byte offset inside a 32-bit word
    localparam int WIDX_W      = LINE_OFF_W - BYTE_OFF_W;

endpackage

// File: rtl/m_cache_refill_if.sv
// Memory read port between the refill engine (master) and the bus controller (slave).
// Latency: data is returned in the same cycle as mack.
// Backpressure: mreq/maddr are held stable until mack.
// Signals: mreq/maddr (request, word address), mack/mdata (ack + read data).
interface m_cache_refill_if #(
    parameter int ADDR_WIDTH = `EADDR_WIDTH
) ();
    logic                  mreq;
    logic [ADDR_WIDTH-1:0] maddr;
    logic                  mack;
    logic [31:0]           mdata;

    modport master (output mreq, output maddr, input mack, input mdata);
    modport slave  (input mreq, input maddr, output mack, output mdata);
endinterface

// File: rtl/m_cache_refill_linebuf.sv
// Line assembly buffer: 4 x 32-bit registers, one word written per cycle, flat 128-bit view.
// Latency: a written word appears on o_line the cycle after i_we.
// Backpressure: none; always accepts a write.
// Ports: i_clk, i_rst_n, i_we/i_widx/i_wdat (word write), o_line (word k at [k*32 +: 32]).
module m_refill_linebuf
    import m_cache_refill_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic [WIDX_W-1:0]    i_widx,
    input  logic [WORD_BITS-1:0] i_wdat,
    output logic [LINE_BITS-1:0] o_line
);
    logic [WORD_BITS-1:0] word_q [LINE_WORDS];
    logic [WORD_BITS-1:0] word_d [LINE_WORDS];

    always_comb begin
        word_d = word_q;
        if (i_we) word_d[i_widx] = i_wdat;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) word_q <= '{default: '0};
        else          word_q <= word_d;
    end

    always_comb begin
        o_line = '0;
        for (int i = 0; i < LINE_WORDS; i++) o_line[i*WORD_BITS +: WORD_BITS] = word_q[i];
    end
endmodule

// File: rtl/m_cache_refill.sv
// Cache line refill engine: on a miss fetches 4 words over mem, then installs the line for one cycle.
// Latency: miss accept -> o_ie in 6 cycles minimum (accept, 4 acks, install).
// Backpressure: waits indefinitely on mem.mack (bounded by MAX_WAIT) and on i_cache_we before install.
// Ports: i_miss/i_maddr (miss), i_cache_we (install block), mem (master memory port),
//        o_ie/o_iaddr/o_idata/o_done (install), o_busy, o_err (ack timeout).
// Optional: CACHE_REFILL_CWF_EN enables critical-word-first order and o_cw_valid/o_cw_data.
module m_cache_refill
    import m_cache_refill_pkg::*;
#(
    parameter int ADDR_WIDTH = `EADDR_WIDTH,
    parameter int MAX_WAIT   = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_miss,
    input  logic [ADDR_WIDTH-1:0] i_maddr,
    input  logic                  i_cache_we,
    output logic                  o_busy,
    m_cache_refill_if.master      mem,
    output logic                  o_ie,
    output logic [ADDR_WIDTH-1:0] o_iaddr,
    output logic [LINE_BITS-1:0]  o_idata,
    output logic                  o_done,
`ifdef CACHE_REFILL_CWF_EN
    output logic                  o_cw_valid,
    output logic [WORD_BITS-1:0]  o_cw_data,
`endif
    output logic                  o_err
);
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int TAG_W  = ADDR_WIDTH - LINE_OFF_W;

    refill_state_e         state_q, state_d;
    logic [TAG_W-1:0]      base_q, base_d;     // line address without the offset bits
    logic [WIDX_W-1:0]     cnt_q, cnt_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  mreq_q, mreq_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic                  err_q, err_d;
    logic [WIDX_W-1:0]     widx;
    logic [WIDX_W-1:0]     first_idx;
    logic                  word_we;
    logic                  unused_addr_bits;

`ifdef CACHE_REFILL_CWF_EN
    logic [WIDX_W-1:0]     start_q, start_d;
    assign first_idx = i_maddr[LINE_OFF_W-1:BYTE_OFF_W];
    assign widx      = start_q + cnt_q;   // wraps within the line
    assign unused_addr_bits = ^i_maddr[BYTE_OFF_W-1:0];
`else
    assign first_idx = '0;
    assign widx      = cnt_q;
    assign unused_addr_bits = ^i_maddr[LINE_OFF_W-1:0];
`endif

    assign word_we = (state_q == ST_FETCH) && mem.mack;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        mreq_d  = mreq_q;
        maddr_d = maddr_q;
        err_d   = 1'b0;
`ifdef CACHE_REFILL_CWF_EN
        start_d = start_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_miss) begin
                    state_d = ST_FETCH;
                    base_d  = i_maddr[ADDR_WIDTH-1:LINE_OFF_W];
                    cnt_d   = '0;
                    wait_d  = '0;
                    mreq_d  = 1'b1;
                    maddr_d = {i_maddr[ADDR_WIDTH-1:LINE_OFF_W], first_idx, {BYTE_OFF_W{1'b0}}};
`ifdef CACHE_REFILL_CWF_EN
                    start_d = first_idx;
`endif
                end
            end
            ST_FETCH: begin
                if (mem.mack) begin
                    wait_d  = '0;
                    cnt_d   = cnt_q + WIDX_W'(1);
                    maddr_d = {base_q, widx + WIDX_W'(1), {BYTE_OFF_W{1'b0}}};
                    if (cnt_q == WIDX_W'(LINE_WORDS - 1)) begin
                        mreq_d  = 1'b0;
                        state_d = ST_INSTALL;
                    end
                end else if (MAX_WAIT > 0 && wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                    // This cycle is the MAX_WAIT-th consecutive one without an ack.
                    err_d   = 1'b1;
                    mreq_d  = 1'b0;
                    wait_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_INSTALL: begin
                if (!i_cache_we) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            mreq_q  <= 1'b0;
            maddr_q <= '0;
            err_q   <= 1'b0;
`ifdef CACHE_REFILL_CWF_EN
            start_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            mreq_q  <= mreq_d;
            maddr_q <= maddr_d;
            err_q   <= err_d;
`ifdef CACHE_REFILL_CWF_EN
            start_q <= start_d;
`endif
        end
    end

    m_refill_linebuf u_linebuf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (word_we),
        .i_widx  (widx),
        .i_wdat  (mem.mdata),
        .o_line  (o_idata)
    );

    assign mem.mreq  = mreq_q;
    assign mem.maddr = maddr_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_iaddr   = {base_q, {LINE_OFF_W{1'b0}}};
    // Install must be suppressed in the very cycle the cache writes, so it gates on the live input.
    assign o_ie      = (state_q == ST_INSTALL) && !i_cache_we;
    assign o_done    = o_ie;
    assign o_err     = err_q;
`ifdef CACHE_REFILL_CWF_EN
    assign o_cw_valid = word_we && (cnt_q == '0);
    assign o_cw_data  = mem.mdata;
`endif
endmodule

// File: tb/tb_m_cache_refill.sv
// Directed + randomized bench for m_cache_refill with an in-bench memory model.
// Latency: n/a.
// Backpressure: bench drives ack delays and i_cache_we stalls.
module tb_m_cache_refill;
    localparam int AW = 32;

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b0;
    logic           i_miss = 1'b0;
    logic [AW-1:0]  i_maddr = '0;
    logic           i_cache_we = 1'b0;
    logic           o_busy, o_ie, o_done, o_err;
    logic [AW-1:0]  o_iaddr;
    logic [127:0]   o_idata;
`ifdef CACHE_REFILL_CWF_EN
    logic           o_cw_valid;
    logic [31:0]    o_cw_data;
`endif

    m_cache_refill_if #(.ADDR_WIDTH(AW)) mem_if ();

    m_cache_refill #(.ADDR_WIDTH(AW), .MAX_WAIT(8)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_miss     (i_miss),
        .i_maddr    (i_maddr),
        .i_cache_we (i_cache_we),
        .o_busy     (o_busy),
        .mem        (mem_if.master),
        .o_ie       (o_ie),
        .o_iaddr    (o_iaddr),
        .o_idata    (o_idata),
        .o_done     (o_done),
`ifdef CACHE_REFILL_CWF_EN
        .o_cw_valid (o_cw_valid),
        .o_cw_data  (o_cw_data),
`endif
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  o_busy, 0);
        check({tag, "_mreq"},  mem_if.mreq, 0);
        check({tag, "_maddr"}, mem_if.maddr, 0);
        check({tag, "_ie"},    o_ie, 0);
        check({tag, "_done"},  o_done, 0);
        check({tag, "_err"},   o_err, 0);
        check({tag, "_iaddr"}, o_iaddr, 0);
        check({tag, "_idata"}, o_idata, 0);
    endtask

    // Index of the k-th word fetched for a miss at addr.
    function automatic int fetch_idx(input logic [31:0] addr, input int k);
`ifdef CACHE_REFILL_CWF_EN
        return (int'(addr[3:2]) + k) % 4;
`else
        return k;
`endif
    endfunction

    // One complete refill. Words of the line are random unless fixed=1 (0xA0..0xA3).
    task automatic refill(input logic [31:0] addr, input int dly, input int we_cyc,
                          input bit stray_miss, input bit fixed);
        logic [31:0]  d [4];
        logic [31:0]  base, exp_addr;
        logic [127:0] line;
        int           idx;
        base = addr & 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++) d[k] = fixed ? 32'hA0 + 32'(k) : $urandom;
        line = {d[3], d[2], d[1], d[0]};

        @(negedge i_clk);
        i_miss = 1'b1; i_maddr = addr; i_cache_we = 1'b0;
        mem_if.mack = 1'b1; mem_if.mdata = $urandom;   // ack in IDLE must be ignored
        #1 check("accept_idle", o_busy, 0);

        for (int k = 0; k < 4; k++) begin
            idx = fetch_idx(addr, k);
            exp_addr = base | 32'(idx << 2);
            for (int w = 0; w <= dly; w++) begin
                @(negedge i_clk);
                i_miss = stray_miss; i_maddr = $urandom;
                mem_if.mack  = (w == dly);
                mem_if.mdata = (w == dly) ? d[idx] : $urandom;
                #1;
                check("fetch_mreq",  mem_if.mreq, 1);
                check("fetch_maddr", mem_if.maddr, exp_addr);
                check("fetch_busy",  o_busy, 1);
                check("fetch_ie",    o_ie, 0);
`ifdef CACHE_REFILL_CWF_EN
                check("cw_valid", o_cw_valid, (k == 0 && w == dly));
                if (k == 0 && w == dly) check("cw_data", o_cw_data, d[int'(addr[3:2])]);
`endif
            end
        end

        for (int w = 0; w < we_cyc; w++) begin
            @(negedge i_clk);
            i_miss = 1'b0; i_cache_we = 1'b1;
            mem_if.mack = 1'($urandom); mem_if.mdata = $urandom;
            #1;
            check("stall_ie",   o_ie, 0);
            check("stall_done", o_done, 0);
            check("stall_busy", o_busy, 1);
            check("stall_mreq", mem_if.mreq, 0);
        end

        @(negedge i_clk);
        i_miss = 1'b0; i_cache_we = 1'b0; mem_if.mack = 1'b0;
        #1;
        check("inst_ie",    o_ie, 1);
        check("inst_done",  o_done, 1);
        check("inst_iaddr", o_iaddr, base);
        check("inst_idata", o_idata, line);
        check("inst_mreq",  mem_if.mreq, 0);

        @(negedge i_clk);
        #1;
        check("post_ie",   o_ie, 0);
        check("post_done", o_done, 0);
        check("post_busy", o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int mreq_cycles;
        bit err_seen;
        mem_if.mack = 1'b0; mem_if.mdata = '0;

        // Reset state
        repeat (2) @(negedge i_clk);
        #1 check_all_zero("reset");
        i_rst_n = 1'b1;

        // Back-to-back acks, fixed data, miss at 0x1238
        refill(32'h0000_1238, 0, 0, 0, 1);
        // Three-cycle ack delay with a stray miss during the fetch
        refill($urandom, 3, 0, 1, 0);
        // Install blocked for 5 cycles by cache writes
        refill($urandom, 0, 5, 0, 0);

        // Reset after the second ack discards the line
        @(negedge i_clk);
        i_miss = 1'b1; i_maddr = 32'h0000_5550; mem_if.mack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            i_miss = 1'b0; mem_if.mack = 1'b1; mem_if.mdata = $urandom;
        end
        @(negedge i_clk);
        i_rst_n = 1'b0; mem_if.mack = 1'b0;
        #1 check_all_zero("midrst");
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            mem_if.mack = 1'($urandom); mem_if.mdata = $urandom;
            #1 check_all_zero("postrst");
        end
        mem_if.mack = 1'b0;
        refill(32'h0000_5554, 0, 0, 0, 0);

        // Timeout with MAX_WAIT=8: no ack ever
        @(negedge i_clk);
        i_miss = 1'b1; i_maddr = 32'h0000_9000; mem_if.mack = 1'b0;
        mreq_cycles = 0; err_seen = 0;
        for (int c = 0; c < 20 && !err_seen; c++) begin
            @(negedge i_clk);
            i_miss = 1'b0;
            #1;
            check("to_ie", o_ie, 0);
            if (mem_if.mreq) mreq_cycles++;
            else err_seen = 1;
        end
        check("to_mreq_cycles", mreq_cycles, 8);
        check("to_err",  o_err, 1);
        check("to_busy", o_busy, 0);
        @(negedge i_clk);
        #1;
        check("to_err_pulse", o_err, 0);
        check("to_no_ie",     o_ie, 0);
        check("to_idle",      o_busy, 0);

        // Randomized refills
        for (int n = 0; n < 8; n++)
            refill($urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
